// File: rtl/aeolus_defs_pkg.sv
// Shared definitions for the Aeolus control unit: opcodes, FSM states, accSrc codes.
// Optional single-step mode is enabled with the AEOLUS_SINGLE_STEP_EN macro.
package aeolus_defs_pkg;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SRC_W   = 2;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDA = 4'h1;
  localparam logic [OP_W-1:0] OP_STA = 4'h2;
  localparam logic [OP_W-1:0] OP_ADD = 4'h3;
  localparam logic [OP_W-1:0] OP_SUB = 4'h4;
  localparam logic [OP_W-1:0] OP_AND = 4'h5;
  localparam logic [OP_W-1:0] OP_OR  = 4'h6;
  localparam logic [OP_W-1:0] OP_XOR = 4'h7;
  localparam logic [OP_W-1:0] OP_NOT = 4'h8;
  localparam logic [OP_W-1:0] OP_IN  = 4'h9;
  localparam logic [OP_W-1:0] OP_OUT = 4'hA;
  localparam logic [OP_W-1:0] OP_JMP = 4'hB;
  localparam logic [OP_W-1:0] OP_JZ  = 4'hC;
  localparam logic [OP_W-1:0] OP_JC  = 4'hD;
  localparam logic [OP_W-1:0] OP_SHL = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  localparam logic [SRC_W-1:0] ACC_SRC_ALU = 2'b00;
  localparam logic [SRC_W-1:0] ACC_SRC_MEM = 2'b01;
  localparam logic [SRC_W-1:0] ACC_SRC_SW  = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_STORE  = 3'd3,
    ST_WB     = 3'd4,
    ST_EXEC   = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  // Instructions that read a memory operand before write-back.
  function automatic logic needs_operand(input logic [OP_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/aeolus_ack_watchdog.sv
// Memory ack watchdog: counts unacknowledged request cycles and flags a timeout.
// A limit of 0 disables the timeout. Used by aeolus_control_unit (AEOLUS_SINGLE_STEP_EN aware via clear).
module aeolus_ack_watchdog
  import aeolus_defs_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_mem_req,
  input  logic i_mem_ack,
  input  logic i_clear,
  output logic o_timeout
);

  localparam bit              WD_EN = (ACK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_waiting;

  assign w_waiting = i_mem_req & ~i_mem_ack;

  // Wait counter: cleared on phase entry, advanced on every unacknowledged request cycle.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (w_waiting) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Timeout fires in the cycle the count would reach the limit; a same-cycle ack suppresses it.
  assign o_timeout = WD_EN && w_waiting && (r_count == LIMIT);

endmodule

// File: rtl/aeolus_control_unit.sv
// Aeolus 8-bit CPU multi-cycle control unit: fetch/decode/mem/store/wb/exec sequencing.
// Define AEOLUS_SINGLE_STEP_EN to add the stepPulse input and single-instruction stepping.
module aeolus_control_unit
  import aeolus_defs_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       boardCLK,
  input  logic       reset,
`ifdef AEOLUS_SINGLE_STEP_EN
  input  logic       stepPulse,
`endif
  input  logic [3:0] opcode,
  input  logic       zeroFlag,
  input  logic       carryFlag,
  input  logic       memAck,
  output logic       memReq,
  output logic       memWe,
  output logic       addrSel,
  output logic       irLoad,
  output logic       pcInc,
  output logic       pcLoad,
  output logic       accLoad,
  output logic       flagsLoad,
  output logic       outLoad,
  output logic [1:0] accSrc,
  output logic [3:0] aluOp,
  output logic       halted,
  output logic       busError
);

  state_t           r_state;
  state_t           w_state_next;

  logic             w_fetch_go;
  logic             w_mem_req;
  logic             w_mem_we;
  logic             w_addr_sel;
  logic             w_ir_load;
  logic             w_pc_inc;
  logic             w_pc_load;
  logic             w_acc_load;
  logic             w_flags_load;
  logic             w_out_load;
  logic [SRC_W-1:0] w_acc_src;
  logic [OP_W-1:0]  w_alu_op;
  logic             w_halted;
  logic             w_bus_error;
  logic             w_timeout;
  logic             w_wd_clear;
  logic             w_step_wait;

`ifdef AEOLUS_SINGLE_STEP_EN
  logic r_step_pending;
  logic w_fetch_ack;

  assign w_fetch_ack = (r_state == ST_FETCH) & w_mem_req & memAck;

  // Step latch: armed by stepPulse, consumed by the instruction fetch ack.
  always_ff @(posedge boardCLK) begin
    if (reset) begin
      r_step_pending <= 1'b0;
    end else begin
      r_step_pending <= stepPulse | (r_step_pending & ~w_fetch_ack);
    end
  end

  assign w_fetch_go = r_step_pending;
`else
  assign w_fetch_go = 1'b1;
`endif

  // Memory request depends only on state so the watchdog timeout has no path back into it.
  assign w_mem_req = ((r_state == ST_FETCH) & w_fetch_go) |
                     (r_state == ST_MEM) | (r_state == ST_STORE);

  assign w_step_wait = (r_state == ST_FETCH) & ~w_fetch_go;
  assign w_wd_clear  = (w_state_next != r_state) | w_step_wait;

  aeolus_ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_watchdog (
    .clk      (boardCLK),
    .reset    (reset),
    .i_mem_req(w_mem_req),
    .i_mem_ack(memAck),
    .i_clear  (w_wd_clear),
    .o_timeout(w_timeout)
  );

  // State register.
  always_ff @(posedge boardCLK) begin
    if (reset) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    w_state_next = r_state;
    w_mem_we     = 1'b0;
    w_addr_sel   = 1'b0;
    w_ir_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_pc_load    = 1'b0;
    w_acc_load   = 1'b0;
    w_flags_load = 1'b0;
    w_out_load   = 1'b0;
    w_acc_src    = ACC_SRC_ALU;
    w_alu_op     = '0;
    w_halted     = 1'b0;
    w_bus_error  = 1'b0;

    case (r_state)
      ST_FETCH: begin
        if (w_fetch_go) begin
          if (memAck) begin
            w_ir_load    = 1'b1;
            w_pc_inc     = 1'b1;
            w_state_next = ST_DECODE;
          end else if (w_timeout) begin
            w_state_next = ST_ERROR;
          end
        end
      end
      ST_DECODE: begin
        if (needs_operand(opcode)) begin
          w_state_next = ST_MEM;
        end else if (opcode == OP_STA) begin
          w_state_next = ST_STORE;
        end else begin
          w_state_next = ST_EXEC;
        end
      end
      ST_MEM: begin
        w_addr_sel = 1'b1;
        if (memAck) begin
          w_state_next = ST_WB;
        end else if (w_timeout) begin
          w_state_next = ST_ERROR;
        end
      end
      ST_STORE: begin
        w_mem_we   = 1'b1;
        w_addr_sel = 1'b1;
        if (memAck) begin
          w_state_next = ST_FETCH;
        end else if (w_timeout) begin
          w_state_next = ST_ERROR;
        end
      end
      ST_WB: begin
        w_acc_load   = 1'b1;
        w_alu_op     = opcode;
        w_state_next = ST_FETCH;
        if (opcode == OP_LDA) begin
          w_acc_src = ACC_SRC_MEM;
        end else begin
          w_flags_load = 1'b1;
        end
      end
      ST_EXEC: begin
        w_alu_op     = opcode;
        w_state_next = ST_FETCH;
        case (opcode)
          OP_NOT, OP_SHL: begin
            w_acc_load   = 1'b1;
            w_flags_load = 1'b1;
          end
          OP_IN: begin
            w_acc_load = 1'b1;
            w_acc_src  = ACC_SRC_SW;
          end
          OP_OUT: w_out_load   = 1'b1;
          OP_JMP: w_pc_load    = 1'b1;
          OP_JZ:  w_pc_load    = zeroFlag;
          OP_JC:  w_pc_load    = carryFlag;
          OP_HLT: w_state_next = ST_HALT;
          default: ;
        endcase
      end
      ST_HALT:  w_halted    = 1'b1;
      ST_ERROR: w_bus_error = 1'b1;
      default:  w_state_next = ST_FETCH;
    endcase
  end

  // Reset masks every output so no strobe leaks out of an aborted instruction.
  assign memReq    = w_mem_req    & ~reset;
  assign memWe     = w_mem_we     & ~reset;
  assign addrSel   = w_addr_sel   & ~reset;
  assign irLoad    = w_ir_load    & ~reset;
  assign pcInc     = w_pc_inc     & ~reset;
  assign pcLoad    = w_pc_load    & ~reset;
  assign accLoad   = w_acc_load   & ~reset;
  assign flagsLoad = w_flags_load & ~reset;
  assign outLoad   = w_out_load   & ~reset;
  assign accSrc    = w_acc_src    & {SRC_W{~reset}};
  assign aluOp     = w_alu_op     & {OP_W{~reset}};
  assign halted    = w_halted     & ~reset;
  assign busError  = w_bus_error  & ~reset;

endmodule

// File: tb/tb_aeolus_control_unit.sv
// Directed self-checking bench for aeolus_control_unit.
// Build with AEOLUS_SINGLE_STEP_EN defined to exercise single-step mode instead of the main sequence.
module tb_aeolus_control_unit;

  logic       boardCLK = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zeroFlag;
  logic       carryFlag;
  logic       memAck;
  logic       memReq, memWe, addrSel, irLoad, pcInc, pcLoad;
  logic       accLoad, flagsLoad, outLoad, halted, busError;
  logic [1:0] accSrc;
  logic [3:0] aluOp;
`ifdef AEOLUS_SINGLE_STEP_EN
  logic       stepPulse;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Observation bit map: {memReq,memWe,addrSel,irLoad,pcInc,pcLoad,accLoad,flagsLoad,outLoad,accSrc[1:0],aluOp[3:0],halted,busError}
  localparam logic [16:0] REQ  = 17'h10000;
  localparam logic [16:0] WE   = 17'h08000;
  localparam logic [16:0] ASEL = 17'h04000;
  localparam logic [16:0] IRL  = 17'h02000;
  localparam logic [16:0] PCI  = 17'h01000;
  localparam logic [16:0] PCL  = 17'h00800;
  localparam logic [16:0] ACC  = 17'h00400;
  localparam logic [16:0] FL   = 17'h00200;
  localparam logic [16:0] OUTL = 17'h00100;
  localparam logic [16:0] HLT  = 17'h00002;
  localparam logic [16:0] BERR = 17'h00001;
  localparam logic [16:0] FA   = REQ | IRL | PCI;
  localparam logic [16:0] MR   = REQ | ASEL;
  localparam logic [16:0] SV   = REQ | WE | ASEL;

  logic [16:0] w_obs;
  assign w_obs = {memReq, memWe, addrSel, irLoad, pcInc, pcLoad, accLoad,
                  flagsLoad, outLoad, accSrc, aluOp, halted, busError};

  function automatic logic [16:0] alu(input logic [3:0] op);
    return 17'(op) << 2;
  endfunction

  function automatic logic [16:0] src(input logic [1:0] s);
    return 17'(s) << 6;
  endfunction

  aeolus_control_unit #(
    .ACK_TIMEOUT(15)
  ) dut (
    .boardCLK (boardCLK),
    .reset    (reset),
`ifdef AEOLUS_SINGLE_STEP_EN
    .stepPulse(stepPulse),
`endif
    .opcode   (opcode),
    .zeroFlag (zeroFlag),
    .carryFlag(carryFlag),
    .memAck   (memAck),
    .memReq   (memReq),
    .memWe    (memWe),
    .addrSel  (addrSel),
    .irLoad   (irLoad),
    .pcInc    (pcInc),
    .pcLoad   (pcLoad),
    .accLoad  (accLoad),
    .flagsLoad(flagsLoad),
    .outLoad  (outLoad),
    .accSrc   (accSrc),
    .aluOp    (aluOp),
    .halted   (halted),
    .busError (busError)
  );

  always #5 boardCLK = ~boardCLK;

  task automatic cyc();
    @(posedge boardCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [16:0] exp);
    n_vec++;
    assert (w_obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%05h expected=%05h", tag, w_obs, exp);
    end
  endtask

  // One cycle: drive memAck, let combinational outputs settle, compare, advance.
  task automatic st(input logic ack, input string tag, input logic [16:0] exp);
    memAck = ack;
    #1;
    chk(tag, exp);
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL bench_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  logic [3:0]  ex_op  [7];
  logic [16:0] ex_exp [7];

  initial begin
    reset     = 1'b1;
    opcode    = 4'h0;
    zeroFlag  = 1'b0;
    carryFlag = 1'b0;
    memAck    = 1'b0;
`ifdef AEOLUS_SINGLE_STEP_EN
    stepPulse = 1'b0;
    cyc();
    st(1'b0, "rst0", 17'h0);
    st(1'b0, "rst1", 17'h0);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) st(1'b1, "step_idle", 17'h0);
    stepPulse = 1'b1;
    st(1'b1, "step_pulse_cycle", 17'h0);
    stepPulse = 1'b0;
    opcode = 4'h0;
    st(1'b1, "step_fetch", FA);
    st(1'b0, "step_decode", 17'h0);
    st(1'b0, "step_exec_nop", 17'h0);
    for (int i = 0; i < 10; i++) st(1'b1, "step_wait_again", 17'h0);
`else
    cyc();
    st(1'b0, "rst0", 17'h0);
    st(1'b0, "rst1", 17'h0);
    reset = 1'b0;

    // ADD 5 with zero-wait memory
    opcode = 4'h3;
    st(1'b1, "add_fetch", FA);
    st(1'b0, "add_decode", 17'h0);
    st(1'b1, "add_mem", MR);
    st(1'b0, "add_wb", ACC | FL | alu(4'h3));

    // LDA loads from memory data
    opcode = 4'h1;
    st(1'b1, "lda_fetch", FA);
    st(1'b0, "lda_decode", 17'h0);
    st(1'b1, "lda_mem", MR);
    st(1'b0, "lda_wb", ACC | src(2'b01) | alu(4'h1));

    // JZ taken then not taken
    opcode = 4'hC;
    zeroFlag = 1'b1;
    st(1'b1, "jz1_fetch", FA);
    st(1'b0, "jz1_decode", 17'h0);
    st(1'b0, "jz1_exec", PCL | alu(4'hC));
    zeroFlag = 1'b0;
    st(1'b1, "jz0_fetch", FA);
    st(1'b0, "jz0_decode", 17'h0);
    st(1'b0, "jz0_exec", alu(4'hC));

    // Remaining EXEC-class opcodes
    carryFlag = 1'b1;
    ex_op[0] = 4'h8; ex_exp[0] = ACC | FL | alu(4'h8);
    ex_op[1] = 4'h9; ex_exp[1] = ACC | src(2'b10) | alu(4'h9);
    ex_op[2] = 4'hA; ex_exp[2] = OUTL | alu(4'hA);
    ex_op[3] = 4'hB; ex_exp[3] = PCL | alu(4'hB);
    ex_op[4] = 4'hD; ex_exp[4] = PCL | alu(4'hD);
    ex_op[5] = 4'hE; ex_exp[5] = ACC | FL | alu(4'hE);
    ex_op[6] = 4'h0; ex_exp[6] = 17'h0;
    for (int i = 0; i < 7; i++) begin
      opcode = ex_op[i];
      st(1'b1, "exec_fetch", FA);
      st(1'b0, "exec_decode", 17'h0);
      st(1'b0, "exec_op", ex_exp[i]);
    end
    carryFlag = 1'b0;
    opcode = 4'hD;
    st(1'b1, "jc0_fetch", FA);
    st(1'b0, "jc0_decode", 17'h0);
    st(1'b0, "jc0_exec", alu(4'hD));

    // STA with three wait cycles
    opcode = 4'h2;
    st(1'b1, "sta_fetch", FA);
    st(1'b0, "sta_decode", 17'h0);
    for (int i = 0; i < 3; i++) st(1'b0, "sta_wait", SV);
    st(1'b1, "sta_ack", SV);

    // Ack on the last permissible cycle beats the timeout
    opcode = 4'h3;
    st(1'b1, "late_fetch", FA);
    st(1'b0, "late_decode", 17'h0);
    for (int i = 0; i < 14; i++) st(1'b0, "late_mem_wait", MR);
    st(1'b1, "late_mem_ack", MR);
    st(1'b0, "late_wb", ACC | FL | alu(4'h3));

    // Watchdog: no ack on fetch
    for (int i = 0; i < 15; i++) st(1'b0, "wd_wait", REQ);
    st(1'b1, "wd_error", BERR);
    for (int i = 0; i < 5; i++) st(1'(i % 2), "wd_error_sticky", BERR);
    reset = 1'b1;
    st(1'b0, "err_reset", 17'h0);
    reset = 1'b0;

    // HLT
    opcode = 4'hF;
    st(1'b1, "hlt_fetch", FA);
    st(1'b0, "hlt_decode", 17'h0);
    st(1'b0, "hlt_exec", alu(4'hF));
    for (int i = 0; i < 100; i++) st(1'(i % 2), "halt_hold", HLT);
    reset = 1'b1;
    st(1'b0, "halt_reset", 17'h0);
    reset = 1'b0;
    st(1'b0, "halt_exit_fetch", REQ);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aeolus_control_unit.md
# aeolus_control_unit

Multi-cycle control unit for the Aeolus 8-bit CPU. It sequences the fetch, decode, execute, memory and write-back phases for the 4-bit opcode set, and drives every load, select and ALU-operation strobe of the datapath. It handshakes with the program/data memory through a req/ack pair guarded by a timeout watchdog. It sits inside `AeolusCPUTop` between the instruction register/flags and the datapath registers.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 15: maximum number of cycles to wait for `memAck`; 0 disables the watchdog.

Ports:
- `boardCLK` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `opcode` in 4: IR[7:4] from the datapath.
- `zeroFlag`, `carryFlag` in 1 each: registered ALU flags.
- `memAck` in 1: memory completes the current request; may be high in the same cycle as `memReq`.
- `memReq` out 1: memory access request.
- `memWe` out 1: write when high, read when low.
- `addrSel` out 1: 0 = PC, 1 = IR[3:0] operand.
- `irLoad`, `pcInc`, `pcLoad`, `accLoad`, `flagsLoad`, `outLoad` out 1 each: single-cycle register strobes.
- `accSrc` out 2: 00 = ALU, 01 = memory data, 10 = switches.
- `aluOp` out 4: ALU function; equals the opcode during WB/EXEC, otherwise 0.
- `halted` out 1: the CPU is stopped by HLT.
- `busError` out 1: the CPU is stopped by the watchdog.

## Operation
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 IN, A OUT, B JMP, C JZ, D JC, E SHL, F HLT.
- States: FETCH, DECODE, MEM, STORE, WB, EXEC, HALT, ERROR.
- FETCH:
  - Asserts `memReq` with `addrSel`=0.
  - On `memAck`: pulses `irLoad` and `pcInc`, then goes to DECODE.
- DECODE: routes the instruction; no strobes.
  - Opcodes 1, 3–7 go to MEM.
  - Opcode 2 goes to STORE.
  - All other opcodes go to EXEC.
- MEM:
  - Asserts `memReq` with `addrSel`=1.
  - On `memAck`, goes to WB.
- WB:
  - LDA: `accLoad`, `accSrc`=01.
  - ALU ops: `accLoad`, `accSrc`=00, `flagsLoad`, `aluOp`=opcode.
  - Then goes to FETCH.
- STORE:
  - Asserts `memReq`, `memWe`, `addrSel`=1.
  - On `memAck`, goes to FETCH.
- EXEC (then goes to FETCH unless HLT):
  - NOT/SHL: `accLoad`, `flagsLoad`, `accSrc`=00.
  - IN: `accLoad`, `accSrc`=10.
  - OUT: `outLoad`.
  - JMP: `pcLoad`.
  - JZ: `pcLoad` only if `zeroFlag`.
  - JC: `pcLoad` only if `carryFlag`.
  - NOP: no strobes.
  - HLT: goes to HALT.
- HALT: `halted`=1 and all strobes 0. Only `reset` leaves this state.
- ERROR: `busError`=1 and all strobes 0. Only `reset` leaves this state.
- Watchdog:
  - A 4-bit wait counter clears on entry to FETCH, MEM and STORE.
  - It increments each cycle that `memReq` is high and `memAck` is low.
  - When it reaches `ACK_TIMEOUT` with `memAck` still low, the FSM goes to ERROR.
  - An ack in that same cycle wins over the timeout.
- `memAck` outside FETCH/MEM/STORE is ignored.

## Timing
- Reset: state FETCH, wait counter 0, step latch 0.
  - Every output is 0 during and after reset until the first FETCH cycle; `memReq` rises in the first cycle after `reset` falls.
- Strobes are Moore outputs decoded from the state register. Ack-qualified strobes (`irLoad`, `pcInc`) are Mealy, gated by `memAck` in the same cycle.
- Cycle counts with zero-wait memory:
  - LDA, ADD–XOR: 4 cycles.
  - STA, NOP, NOT–HLT: 3 cycles.
  - Each memory wait cycle adds 1.
- Reset mid-instruction aborts it immediately; no strobe is issued in the reset cycle.

## Configuration
- `AEOLUS_SINGLE_STEP_EN` defined:
  - Adds input `stepPulse` (1 bit) and an internal `stepPending` latch.
  - `stepPending` sets on `stepPulse` and clears on the fetch ack.
  - FETCH asserts `memReq` only while `stepPending`=1; the watchdog counter is held at 0 while waiting for a step.
- `AEOLUS_SINGLE_STEP_EN` undefined: `stepPulse` is absent and FETCH requests unconditionally.

## Structure
- Shared package/header `aeolus_defs`: opcode constants, state encodings, `accSrc` encodings.
- One sub-module, `aeolus_ack_watchdog`: the wait counter plus timeout compare. It takes `memReq`, `memAck` and a clear input, and outputs `timeout`.
- The FSM and output decode remain in `aeolus_control_unit`.

## Test plan
- Reset held 2 cycles, then released; zero-wait memory, IR=0x3_5 (ADD 5) → states FETCH, DECODE, MEM, WB. `accLoad`=1, `aluOp`=3, `flagsLoad`=1 in cycle 4; `memReq` rises in cycle 1.
- JZ with `zeroFlag`=1 → `pcLoad`=1 in EXEC. Repeat with `zeroFlag`=0 → `pcLoad`=0 and the next FETCH follows.
- STA with `memAck` delayed 3 cycles → `memWe`=1 and `addrSel`=1 held for 4 cycles, then FETCH.
- `ACK_TIMEOUT`=15, `memAck` tied low → `busError`=1 exactly 15 cycles after `memReq` rises; the state sticks in ERROR until `reset`.
- HLT → `halted`=1 and all strobes 0 for 100 cycles. Asserting `reset` returns to FETCH with `halted`=0 on the next edge.
- With `AEOLUS_SINGLE_STEP_EN`: no `memReq` for 50 cycles; one `stepPulse` executes exactly one NOP, then the FSM waits again.
